// File: rtl/rx_pattern_checker.sv
// Receive-side frame pattern checker: hunts for the comma frame, verifies
// LOCK_FRAMES good frames, then reports bad words and drops lock after a bad run.

module rx_pattern_checker_byte (
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       not_in_table,
  input  logic [7:0] exp_data,
  input  logic       exp_k,
  output logic       ok
);
  assign ok = (data == exp_data) && (is_k == exp_k) && !not_in_table;
endmodule

module rx_pattern_checker #(
  parameter logic [7:0] K_BYTE      = 8'hBC,
  parameter logic [7:0] FILL_BYTE   = 8'h4A,
  parameter int         FRAME_WORDS = 4,
  parameter int         LOCK_FRAMES = 4,
  parameter int         LOSS_THRESH = 8
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_char_is_k_i,
  input  logic [1:0]  rx_not_in_table_i,
  input  logic        rx_byte_is_aligned_i,
  input  logic        cnt_clear_i,
  output logic        locked_o,
  output logic        err_o,
  output logic        lol_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] frame_cnt_o
);
  localparam int NUM_LANES = 2;
  localparam int IDX_W     = $clog2(FRAME_WORDS);
  localparam int GF_W      = $clog2(LOCK_FRAMES + 1);
  localparam int RUN_W     = $clog2(LOSS_THRESH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [GF_W-1:0]  GF_LAST  = GF_W'(LOCK_FRAMES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][7:0] data;
    logic [NUM_LANES-1:0]      is_k;
    logic [NUM_LANES-1:0]      nit;
  } rx_word_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [GF_W-1:0]             good_frames;
  logic [RUN_W-1:0]            bad_run;
  logic                        frame_bad;

  rx_word_t                    rx_w;
  logic [NUM_LANES-1:0][7:0]   exp_data;
  logic [NUM_LANES-1:0]        exp_k;
  logic [NUM_LANES-1:0]        lane_ok;
  logic                        at_zero, idx_last, word_good;
  logic [IDX_W-1:0]            idx_next;
  logic                        err_inc, frame_inc;

  assign rx_w = '{data: rx_data_i, is_k: rx_char_is_k_i, nit: rx_not_in_table_i};

  assign at_zero  = (idx == '0);
  assign idx_last = (idx == LAST_IDX);
  assign idx_next = idx_last ? '0 : idx + IDX_W'(1);

  // Only the earlier byte of word 0 carries the comma; everything else is fill data.
  assign exp_data[0] = at_zero ? K_BYTE : FILL_BYTE;
  assign exp_k[0]    = at_zero;
  assign exp_data[1] = FILL_BYTE;
  assign exp_k[1]    = 1'b0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_pattern_checker_byte u_byte (
      .data         (rx_w.data[g]),
      .is_k         (rx_w.is_k[g]),
      .not_in_table (rx_w.nit[g]),
      .exp_data     (exp_data[g]),
      .exp_k        (exp_k[g]),
      .ok           (lane_ok[g])
    );
  end

  assign word_good = (&lane_ok) && rx_byte_is_aligned_i;
  assign err_inc   = (state == LOCKED) && !word_good;
  assign frame_inc = (state == LOCKED) && word_good && idx_last && !frame_bad;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state       <= HUNT;
      idx         <= '0;
      good_frames <= '0;
      bad_run     <= '0;
      frame_bad   <= 1'b0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      lol_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      lol_o <= 1'b0;
      unique case (state)
        HUNT: begin
          if (word_good) begin
            state       <= VERIFY;
            idx         <= IDX_W'(1);
            good_frames <= '0;
          end else begin
            idx <= '0;
          end
        end
        VERIFY: begin
          if (!word_good) begin
            state <= HUNT;
            idx   <= '0;
          end else begin
            idx <= idx_next;
            if (idx_last) begin
              good_frames <= good_frames + GF_W'(1);
              if (good_frames == GF_LAST) begin
                state     <= LOCKED;
                locked_o  <= 1'b1;
                bad_run   <= '0;
                frame_bad <= 1'b0;
              end
            end
          end
        end
        LOCKED: begin
          // Phase is free-running here; a misplaced comma is an error, not a re-sync.
          idx <= idx_next;
          if (idx_last)        frame_bad <= 1'b0;
          else if (!word_good) frame_bad <= 1'b1;
          if (word_good) begin
            bad_run <= '0;
          end else begin
            err_o <= 1'b1;
            if (bad_run == RUN_LAST) begin
              state     <= HUNT;
              locked_o  <= 1'b0;
              lol_o     <= 1'b1;
              bad_run   <= '0;
              idx       <= '0;
              frame_bad <= 1'b0;
            end else begin
              bad_run <= bad_run + RUN_W'(1);
            end
          end
        end
        default: begin
          state    <= HUNT;
          idx      <= '0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  // Statistics survive lock loss; only reset or an explicit clear zeroes them.
  always_ff @(posedge rx_clk) begin
    if (rst || cnt_clear_i) begin
      err_cnt_o   <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (err_inc && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
      if (frame_inc)                          frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_rx_pattern_checker.sv
// Bench for rx_pattern_checker: vector table, hand-written corner sequences,
// and a randomized run compared against a frame-level reference model.

module tb_rx_pattern_checker;
  localparam logic [7:0] KB = 8'hBC;
  localparam logic [7:0] FB = 8'h4A;
  localparam int FW = 4;
  localparam int LF = 4;
  localparam int LT = 8;

  logic        rx_clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_k = '0, rx_nit = '0;
  logic        rx_al = 1'b1, clr = 1'b0;

  logic        locked, err, lol;
  logic [15:0] ecnt, fcnt;
  logic        s_locked, s_err, s_lol;
  logic [15:0] s_ecnt, s_fcnt;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame-level view of the link).
  int m_mode;  // 0 hunting, 1 verifying, 2 locked
  int m_idx, m_gf, m_run, m_ecnt, m_fcnt;
  bit m_fbad, m_err, m_lol;

  always #5 rx_clk = ~rx_clk;

  rx_pattern_checker dut (
    .rx_clk(rx_clk), .rst(rst), .rx_data_i(rx_data), .rx_char_is_k_i(rx_k),
    .rx_not_in_table_i(rx_nit), .rx_byte_is_aligned_i(rx_al), .cnt_clear_i(clr),
    .locked_o(locked), .err_o(err), .lol_o(lol), .err_cnt_o(ecnt), .frame_cnt_o(fcnt)
  );

  // Second instance that never loses lock, so the error counter can be driven to saturation.
  rx_pattern_checker #(.LOSS_THRESH(100000)) dut_sat (
    .rx_clk(rx_clk), .rst(rst), .rx_data_i(rx_data), .rx_char_is_k_i(rx_k),
    .rx_not_in_table_i(rx_nit), .rx_byte_is_aligned_i(rx_al), .cnt_clear_i(clr),
    .locked_o(s_locked), .err_o(s_err), .lol_o(s_lol), .err_cnt_o(s_ecnt), .frame_cnt_o(s_fcnt)
  );

  function automatic logic [15:0] exp_word(input int i);
    return (i == 0) ? {FB, KB} : {FB, FB};
  endfunction

  function automatic logic [1:0] exp_kf(input int i);
    return (i == 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit,
                            input logic al, input logic c, input logic r);
    bit good, last;
    m_err = 0;
    m_lol = 0;
    if (r) begin
      m_mode = 0; m_idx = 0; m_gf = 0; m_run = 0; m_ecnt = 0; m_fcnt = 0; m_fbad = 0;
      return;
    end
    good = (d == exp_word(m_idx)) && (k == exp_kf(m_idx)) && (nit == 2'b00) && al;
    last = (m_idx == FW - 1);
    if (m_mode == 0) begin
      if (good) begin m_mode = 1; m_idx = 1; m_gf = 0; end
    end else if (m_mode == 1) begin
      if (!good) begin
        m_mode = 0; m_idx = 0;
      end else begin
        m_idx = (m_idx + 1) % FW;
        if (last) m_gf++;
        if (m_gf == LF) begin m_mode = 2; m_run = 0; m_fbad = 0; end
      end
    end else begin
      if (!good) begin
        m_err = 1;
        if (m_ecnt < 65535) m_ecnt++;
        m_run++;
      end else begin
        m_run = 0;
        if (last && !m_fbad) m_fcnt = (m_fcnt + 1) % 65536;
      end
      m_fbad = last ? 0 : (m_fbad || !good);
      m_idx = (m_idx + 1) % FW;
      if (m_run == LT) begin m_mode = 0; m_lol = 1; m_run = 0; m_idx = 0; m_fbad = 0; end
    end
    if (c) begin m_ecnt = 0; m_fcnt = 0; end
  endtask

  task automatic apply(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit,
                       input logic al, input logic c, input logic r);
    rx_data = d; rx_k = k; rx_nit = nit; rx_al = al; clr = c; rst = r;
    model_step(d, k, nit, al, c, r);
    @(posedge rx_clk);
    #1;
  endtask

  task automatic clean(input int i);
    apply(exp_word(i), exp_kf(i), 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, locked, err, lol, ecnt, fcnt};
  endfunction

  function automatic logic [63:0] pack(input logic l, input logic e, input logic o,
                                       input logic [15:0] ec, input logic [15:0] fc);
    return {29'd0, l, e, o, ec, fc};
  endfunction

  typedef struct {
    logic [15:0] d; logic [1:0] k; logic [1:0] nit; logic al; logic clr; logic r;
    logic locked; logic err; logic lol; logic [15:0] ecnt; logic [15:0] fcnt;
  } vec_t;

  vec_t vt[37];

  initial begin
    // ---- vector table: lock, count frames, assorted single-word errors while locked
    vt[0] = '{16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    for (int w = 1; w <= 36; w++) begin
      int i;
      i = (w - 1) % FW;
      vt[w] = '{exp_word(i), exp_kf(i), 2'b00, 1'b1, 1'b0, 1'b0,
                (w >= 16), 1'b0, 1'b0, 16'd0,
                16'((w >= 36) ? 3 : (w >= 28) ? 2 : (w >= 20) ? 1 : 0)};
    end
    vt[22].d = 16'h4A4B;            // corrupted data byte
    vt[29].al = 1'b0;               // alignment lost
    vt[30].nit = 2'b10;             // code violation in high byte
    vt[31].k = 2'b01;               // spurious K flag
    vt[32].d = 16'h4ABC; vt[32].k = 2'b01;  // comma at wrong index
    for (int w = 22; w <= 36; w++) vt[w].ecnt = 16'((w >= 32) ? 5 : (w >= 29) ? w - 27 : 1);
    foreach (vt[w]) if (w == 22 || (w >= 29 && w <= 32)) vt[w].err = 1'b1;

    for (int w = 0; w < 37; w++) begin
      apply(vt[w].d, vt[w].k, vt[w].nit, vt[w].al, vt[w].clr, vt[w].r);
      check($sformatf("vec[%0d]", w), outs(),
            pack(vt[w].locked, vt[w].err, vt[w].lol, vt[w].ecnt, vt[w].fcnt));
    end

    // ---- 8 consecutive bad words drop lock; re-lock keeps the error count
    do_reset();
    check("reset_outs", outs(), 64'd0);
    for (int i = 0; i < 16; i++) clean(i % FW);
    check("lock_after_16", outs(), pack(1'b1, 1'b0, 1'b0, 16'd0, 16'd0));
    for (int j = 0; j < LT; j++) begin
      apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      check($sformatf("badrun[%0d]", j), outs(),
            pack(j != LT - 1, 1'b1, j == LT - 1, 16'(j + 1), 16'd0));
    end
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("hunt_no_err", outs(), pack(1'b0, 1'b0, 1'b0, 16'd8, 16'd0));
    for (int i = 0; i < 15; i++) clean(i % FW);
    check("relock_not_yet", outs(), pack(1'b0, 1'b0, 1'b0, 16'd8, 16'd0));
    clean(3);
    check("relock", outs(), pack(1'b1, 1'b0, 1'b0, 16'd8, 16'd0));
    for (int i = 0; i < 4; i++) clean(i);
    check("frame_after_relock", outs(), pack(1'b1, 1'b0, 1'b0, 16'd8, 16'd1));
    apply(16'h1234, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check("clr_with_err", outs(), pack(1'b1, 1'b1, 1'b0, 16'd0, 16'd0));

    // ---- comma in the high byte never locks
    do_reset();
    begin
      bit ever = 0;
      for (int i = 0; i < 40; i++) begin
        apply({KB, FB}, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        ever |= locked;
      end
      check("hi_comma_never_lock", {63'd0, ever}, 64'd0);
      check("hi_comma_outs", outs(), 64'd0);
    end

    // ---- reset mid-frame while locked, then fresh lock
    do_reset();
    for (int i = 0; i < 18; i++) clean(i % FW);
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("pre_rst_err", outs(), pack(1'b1, 1'b1, 1'b0, 16'd1, 16'd0));
    do_reset();
    check("rst_locked", outs(), 64'd0);
    for (int i = 0; i < 15; i++) clean(i % FW);
    check("post_rst_15", outs(), 64'd0);
    clean(3);
    check("post_rst_16", outs(), pack(1'b1, 1'b0, 1'b0, 16'd0, 16'd0));

    // ---- randomized run against the reference model
    do_reset();
    for (int cyc = 0; cyc < 2400; cyc++) begin
      logic [15:0] d; logic [1:0] k, nit; logic al, c, r;
      int rate;
      rate = ((cyc / 150) % 3 == 2) ? 60 : 3;
      d = exp_word(m_idx); k = exp_kf(m_idx); nit = 2'b00; al = 1'b1;
      if ($urandom_range(0, 99) < rate) begin
        case ($urandom_range(0, 5))
          0: d = 16'($urandom);
          1: k = 2'($urandom_range(0, 3));
          2: nit = 2'($urandom_range(1, 3));
          3: al = 1'b0;
          4: begin d = {KB, FB}; k = 2'b10; end
          default: begin d = {FB, KB}; k = 2'b01; end
        endcase
      end
      c = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 499) == 0);
      apply(d, k, nit, al, c, r);
      check($sformatf("rand[%0d]", cyc), outs(),
            pack(m_mode == 2, m_err, m_lol, 16'(m_ecnt), 16'(m_fcnt)));
    end

    // ---- error counter saturation and clear-vs-increment priority
    do_reset();
    for (int i = 0; i < 16; i++) clean(i % FW);
    check("sat_locked", {63'd0, s_locked}, 64'd1);
    for (int i = 0; i < 65534; i++) apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("sat_fffe", {48'd0, s_ecnt}, 64'hFFFE);
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("sat_ffff", {48'd0, s_ecnt}, 64'hFFFF);
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("sat_hold", {47'd0, s_err, s_ecnt}, {47'd0, 1'b1, 16'hFFFF});
    apply(16'h0000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check("sat_clr_err", {31'd0, s_locked, s_err, s_lol, s_ecnt, s_fcnt},
          pack(1'b1, 1'b1, 1'b0, 16'd0, 16'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
